// File: rtl/axi_console_sniffer_if.sv
// axi_console_sniffer_if: snooped CPU-side AXI AW/W channel signals
interface axi_console_sniffer_if;
   logic         awvalid;
   logic         awready;
   logic [39:0]  awaddr;
   logic [3:0]   awlen;
   logic         wvalid;
   logic         wready;
   logic [127:0] wdata;
   logic [15:0]  wstrb;
   logic         wlast;
   modport master (output awvalid, awready, awaddr, awlen, wvalid, wready, wdata, wstrb, wlast);
   modport slave  (input  awvalid, awready, awaddr, awlen, wvalid, wready, wdata, wstrb, wlast);
endinterface

// File: rtl/axi_console_sniffer.sv
// axi_console_sniffer: passive AXI write snooper extracting console characters into a FIFO, plus retire watchdog
module axi_console_sniffer #(
   parameter logic [31:0] CON_ADDR = 32'h9000_0000,
   parameter int          AWQ_DEP  = 4,
   parameter int          FIFO_DEP = 16,
   parameter int          WDOG_CYC = 50000
) (
   input  logic                   clk,
   input  logic                   rst_b,
   axi_console_sniffer_if.slave   bus,
   input  logic                   retire_i,
   input  logic                   char_ready_i,
   output logic                   char_valid_o,
   output logic [7:0]             char_data_o,
   output logic [15:0]            drop_cnt_o,
   output logic                   proto_err_o,
   output logic                   wdog_fail_o
);
   localparam int AQW = $clog2(AWQ_DEP);
   localparam int FW  = $clog2(FIFO_DEP);
   localparam int WW  = $clog2(WDOG_CYC);
   localparam logic [WW-1:0] WIN_LAST = WW'(WDOG_CYC - 1);

   logic               aw_hs, w_hs, new_hit, head_hit, head_ok, orphan;
   logic               awq_empty, awq_full, aw_push, aw_pop, aw_ovf;
   logic [AWQ_DEP-1:0] awq_q;
   logic [AQW-1:0]     awq_rd_q, awq_rd_d, awq_wr_q, awq_wr_d;
   logic [AQW:0]       awq_cnt_q, awq_cnt_d;
   logic [1:0]         lane;
   logic               lane_ok, ext;
   logic [7:0]         ch;
   logic [7:0]         fifo_q [FIFO_DEP];
   logic [FW-1:0]      f_rd_q, f_rd_d, f_wr_q, f_wr_d;
   logic [FW:0]        f_cnt_q, f_cnt_d;
   logic               f_full, f_pop, f_push, f_drop;
   logic               char_valid_q, char_valid_d;
   logic [7:0]         char_data_q, char_data_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;
   logic               perr_q, perr_d;
   logic [WW-1:0]      win_q, win_d;
   logic [31:0]        ret_q, ret_d;
   logic               wrap, wdog_q, wdog_d;
   logic               unused_awaddr;

   assign unused_awaddr = ^bus.awaddr[39:32];

   // AW queue bookkeeping: a W beat on an empty queue borrows a same-cycle AW instead of storing it
   always_comb begin
      aw_hs     = bus.awvalid & bus.awready;
      w_hs      = bus.wvalid & bus.wready;
      new_hit   = (bus.awaddr[31:0] == CON_ADDR) && (bus.awlen == 4'd0);
      awq_empty = awq_cnt_q == '0;
      awq_full  = awq_cnt_q == (AQW+1)'(AWQ_DEP);
      orphan    = w_hs & awq_empty & ~aw_hs;
      head_ok   = w_hs & ~orphan;
      head_hit  = awq_empty ? new_hit : awq_q[awq_rd_q];
      aw_pop    = head_ok & bus.wlast & ~awq_empty;
      aw_push   = aw_hs & ~(awq_empty & w_hs & bus.wlast) & (~awq_full | aw_pop);
      aw_ovf    = aw_hs & awq_full & ~aw_pop;
      awq_rd_d  = awq_rd_q + AQW'(aw_pop);
      awq_wr_d  = awq_wr_q + AQW'(aw_push);
      awq_cnt_d = awq_cnt_q + (AQW+1)'(aw_push) - (AQW+1)'(aw_pop);
      perr_d    = perr_q | orphan | aw_ovf;
   end

   // Character extraction: exactly one full 32-bit lane strobed on a console hit
   always_comb begin
      lane    = (bus.wstrb == 16'h000F) ? 2'd0 :
                (bus.wstrb == 16'h00F0) ? 2'd1 :
                (bus.wstrb == 16'h0F00) ? 2'd2 : 2'd3;
      lane_ok = bus.wstrb inside {16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
      ch      = bus.wdata[{lane, 5'd0} +: 8];
      ext     = head_ok & head_hit & lane_ok;
   end

   // Character FIFO with a registered head so char_data stays put under backpressure
   always_comb begin
      f_full       = f_cnt_q == (FW+1)'(FIFO_DEP);
      f_pop        = char_valid_q & char_ready_i;
      f_push       = ext & (~f_full | f_pop);
      f_drop       = ext & f_full & ~f_pop;
      f_rd_d       = f_rd_q + FW'(f_pop);
      f_wr_d       = f_wr_q + FW'(f_push);
      f_cnt_d      = f_cnt_q + (FW+1)'(f_push) - (FW+1)'(f_pop);
      char_valid_d = f_cnt_d != '0;
      char_data_d  = (f_cnt_d == '0) ? char_data_q :
                     (f_push && f_wr_q == f_rd_d) ? ch : fifo_q[f_rd_d];
      drop_cnt_d   = drop_cnt_q + 16'(f_drop & ~&drop_cnt_q);
   end

   // Retire watchdog: a window with zero retires latches the failure flag
   always_comb begin
      wrap   = win_q == WIN_LAST;
      win_d  = wrap ? '0 : win_q + WW'(1);
      ret_d  = wrap ? '0 : ret_q + 32'(retire_i & ~&ret_q);
      wdog_d = wdog_q | (wrap & (ret_q == '0) & ~retire_i);
   end

   // Storage arrays carry no reset; occupancy counters guard every read
   always_ff @(posedge clk) begin
      if (aw_push) awq_q[awq_wr_q] <= new_hit;
      if (f_push) fifo_q[f_wr_q] <= ch;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         awq_rd_q     <= '0;
         awq_wr_q     <= '0;
         awq_cnt_q    <= '0;
         f_rd_q       <= '0;
         f_wr_q       <= '0;
         f_cnt_q      <= '0;
         char_valid_q <= 1'b0;
         char_data_q  <= '0;
         drop_cnt_q   <= '0;
         perr_q       <= 1'b0;
         win_q        <= '0;
         ret_q        <= '0;
         wdog_q       <= 1'b0;
      end else begin
         awq_rd_q     <= awq_rd_d;
         awq_wr_q     <= awq_wr_d;
         awq_cnt_q    <= awq_cnt_d;
         f_rd_q       <= f_rd_d;
         f_wr_q       <= f_wr_d;
         f_cnt_q      <= f_cnt_d;
         char_valid_q <= char_valid_d;
         char_data_q  <= char_data_d;
         drop_cnt_q   <= drop_cnt_d;
         perr_q       <= perr_d;
         win_q        <= win_d;
         ret_q        <= ret_d;
         wdog_q       <= wdog_d;
      end
   end

   assign char_valid_o = char_valid_q;
   assign char_data_o  = char_data_q;
   assign drop_cnt_o   = drop_cnt_q;
   assign proto_err_o  = perr_q;
   assign wdog_fail_o  = wdog_q;
endmodule

// File: tb/tb_axi_console_sniffer.sv
// tb_axi_console_sniffer: randomized and directed checks against a queue-based reference model
module tb_axi_console_sniffer;
   localparam int          WDOG = 2500;
   localparam int          AWQ  = 4;
   localparam int          FDEP = 16;
   localparam logic [39:0] CON  = 40'h00_9000_0000;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        retire, char_ready, char_valid, proto_err, wdog_fail;
   logic [7:0]  char_data;
   logic [15:0] drop_cnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   axi_console_sniffer_if bus ();

   axi_console_sniffer #(.WDOG_CYC(WDOG)) dut (
      .clk(clk), .rst_b(rst_b), .bus(bus),
      .retire_i(retire), .char_ready_i(char_ready),
      .char_valid_o(char_valid), .char_data_o(char_data), .drop_cnt_o(drop_cnt),
      .proto_err_o(proto_err), .wdog_fail_o(wdog_fail)
   );

   // Reference model: AW hits as a queue, visible characters as a queue, watchdog by last retire time
   bit          m_awq [$];
   logic [7:0]  m_ch [$];
   int          m_drop, m_k;
   bit          m_perr, m_wdog, m_aw, m_w, m_pa;
   longint      m_n, m_last;
   logic [15:0] strbs [6] = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h00FF, 16'h0000};

   always @(posedge clk) begin
      if (!rst_b) begin
         m_awq.delete(); m_ch.delete();
         m_drop = 0; m_perr = 0; m_wdog = 0; m_n = 0; m_last = -1;
      end else begin
         m_aw = bus.awvalid && bus.awready;
         m_w  = bus.wvalid && bus.wready;
         m_pa = m_w && bus.wlast && m_awq.size() > 0;
         if (m_ch.size() > 0 && char_ready) void'(m_ch.pop_front());
         if (m_aw) begin
            if (m_awq.size() == AWQ && !m_pa) m_perr = 1;
            else m_awq.push_back(bus.awaddr[31:0] == 32'h9000_0000 && bus.awlen == 4'd0);
         end
         if (m_w) begin
            if (m_awq.size() == 0) m_perr = 1;
            else begin
               m_k = -1;
               for (int i = 0; i < 4; i++) if (bus.wstrb == (16'hF << (4*i))) m_k = i;
               if (m_awq[0] && m_k >= 0) begin
                  if (m_ch.size() == FDEP) m_drop++;
                  else m_ch.push_back(bus.wdata[32*m_k +: 8]);
               end
               if (bus.wlast) void'(m_awq.pop_front());
            end
         end
         if (retire) m_last = m_n;
         if (m_n % WDOG == WDOG - 1 && m_last < m_n - WDOG + 1) m_wdog = 1;
         m_n++;
      end
   end

   function automatic logic [127:0] lane_data(input int k, input logic [7:0] c);
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      d[32*k +: 8] = c;
      return d;
   endfunction

   function automatic logic [15:0] lane_strb(input int k);
      return 16'hF << (4*k);
   endfunction

   task automatic do_reset(input logic ret);
      rst_b = 1'b0;
      bus.awvalid = 0; bus.awready = 1; bus.awaddr = '0; bus.awlen = '0;
      bus.wvalid = 0; bus.wready = 1; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
      char_ready = 0; retire = ret;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
   endtask

   task automatic aw_beat(input logic [39:0] a, input logic [3:0] l);
      bus.awvalid = 1; bus.awaddr = a; bus.awlen = l;
      @(negedge clk);
      bus.awvalid = 0;
   endtask

   task automatic w_beat(input logic [127:0] d, input logic [15:0] s, input logic last);
      bus.wvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wlast = last;
      @(negedge clk);
      bus.wvalid = 0;
   endtask

   task automatic aw_w_beat(input logic [39:0] a, input logic [3:0] l, input logic [127:0] d,
                            input logic [15:0] s, input logic last);
      bus.awvalid = 1; bus.awaddr = a; bus.awlen = l;
      bus.wvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wlast = last;
      @(negedge clk);
      bus.awvalid = 0; bus.wvalid = 0;
   endtask

   task automatic test_reset();
      do_reset(1);
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", char_valid); end
      checks++; if (char_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", char_data); end
      checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", proto_err); end
      checks++; if (wdog_fail !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %b want 0", wdog_fail); end
   endtask

   task automatic test_single();
      do_reset(1);
      aw_beat(CON, 4'd0);
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", char_valid); end
      w_beat(lane_data(1, 8'h41), 16'h00F0, 1);
      checks++; if (char_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", char_valid); end
      checks++; if (char_data !== 8'h41) begin errors++; $display("FAIL single_data: got %h want 41", char_data); end
      char_ready = 1;
      @(negedge clk);
      char_ready = 0;
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", char_valid); end
   endtask

   task automatic test_same_cycle();
      do_reset(1);
      aw_w_beat(CON, 4'd0, lane_data(3, 8'h0A), 16'hF000, 1);
      checks++; if (char_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b want 1", char_valid); end
      checks++; if (char_data !== 8'h0A) begin errors++; $display("FAIL bypass_data: got %h want 0a", char_data); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL bypass_perr: got %b want 0", proto_err); end
   endtask

   task automatic test_filtered();
      do_reset(1);
      aw_beat(CON, 4'd3);
      for (int i = 0; i < 4; i++) w_beat(lane_data(0, 8'h58), 16'h000F, i == 3);
      aw_beat(40'h00_8000_0000, 4'd0);
      w_beat(lane_data(0, 8'h59), 16'h000F, 1);
      aw_beat(CON, 4'd0);
      w_beat(lane_data(0, 8'h5A), 16'h00FF, 1);
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL filtered_valid: got %b want 0", char_valid); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL filtered_perr: got %b want 0", proto_err); end
      w_beat(lane_data(0, 8'h5B), 16'h000F, 1);
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL filtered_queue_empty: got %b want 1", proto_err); end
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL filtered_orphan_char: got %b want 0", char_valid); end
   endtask

   task automatic test_fifo_full();
      logic [7:0] exp;
      do_reset(1);
      for (int i = 0; i < 20; i++) aw_w_beat(CON, 4'd0, lane_data(i % 4, 8'h61 + 8'(i)), lane_strb(i % 4), 1);
      checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL full_drop: got %0d want 4", drop_cnt); end
      checks++; if (char_data !== 8'h61) begin errors++; $display("FAIL full_head: got %h want 61", char_data); end
      char_ready = 1;
      aw_w_beat(CON, 4'd0, lane_data(2, 8'h5A), 16'h0F00, 1);
      checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL full_pop_push_drop: got %0d want 4", drop_cnt); end
      for (int j = 0; j < 16; j++) begin
         exp = (j < 15) ? 8'h62 + 8'(j) : 8'h5A;
         checks++; if (char_valid !== 1'b1 || char_data !== exp) begin errors++; $display("FAIL full_drain[%0d]: got v=%b %h want v=1 %h", j, char_valid, char_data, exp); end
         checks++; if (m_ch.size() == 0 || char_data !== m_ch[0]) begin errors++; $display("FAIL full_drain_model[%0d]: got %h model size %0d", j, char_data, m_ch.size()); end
         @(negedge clk);
      end
      char_ready = 0;
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", char_valid); end
   endtask

   task automatic test_proto();
      do_reset(1);
      w_beat(lane_data(0, 8'h31), 16'h000F, 1);
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL orphan_perr: got %b want 1", proto_err); end
      for (int i = 0; i < 5; i++) aw_beat(CON, 4'd0);
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", proto_err); end
      do_reset(1);
      for (int i = 0; i < 5; i++) begin
         aw_beat(CON, 4'd0);
         if (i == 3) begin
            checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", proto_err); end
         end
      end
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL ovf_perr: got %b want 1", proto_err); end
      repeat (10) @(negedge clk);
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", proto_err); end
   endtask

   task automatic test_back_to_back();
      do_reset(1);
      for (int i = 0; i < 4; i++) aw_beat(CON, 4'd0);
      aw_w_beat(CON, 4'd0, lane_data(2, 8'h30), 16'h0F00, 1);
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_full_pushpop: got %b want 0", proto_err); end
      for (int i = 1; i < 5; i++) w_beat(lane_data(i % 4, 8'h30 + 8'(i)), lane_strb(i % 4), 1);
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_perr: got %b want 0", proto_err); end
      char_ready = 1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (char_valid !== 1'b1 || char_data !== 8'h30 + 8'(i)) begin errors++; $display("FAIL b2b_char[%0d]: got v=%b %h want %h", i, char_valid, char_data, 8'h30 + 8'(i)); end
         @(negedge clk);
      end
      char_ready = 0;
      w_beat(lane_data(0, 8'h39), 16'h000F, 1);
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL b2b_drained_queue: got %b want 1", proto_err); end
   endtask

   task automatic test_reset_mid();
      do_reset(1);
      aw_w_beat(CON, 4'd0, lane_data(0, 8'h71), 16'h000F, 1);
      aw_beat(CON, 4'd3);
      w_beat(lane_data(0, 8'h72), 16'h000F, 0);
      checks++; if (char_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", char_valid); end
      do_reset(1);
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", char_valid); end
      checks++; if (char_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h want 00", char_data); end
      w_beat(lane_data(0, 8'h73), 16'h000F, 1);
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL mid_discarded: got %b want 1", proto_err); end
   endtask

   task automatic test_random();
      do_reset(1);
      for (int c = 0; c < 800; c++) begin
         checks++; if (char_valid !== (m_ch.size() != 0)) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", c, char_valid, m_ch.size() != 0); end
         if (m_ch.size() != 0) begin
            checks++; if (char_data !== m_ch[0]) begin errors++; $display("FAIL rnd_data @%0d: got %h want %h", c, char_data, m_ch[0]); end
         end
         checks++; if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL rnd_drop @%0d: got %0d want %0d", c, drop_cnt, m_drop); end
         checks++; if (proto_err !== m_perr) begin errors++; $display("FAIL rnd_perr @%0d: got %b want %b", c, proto_err, m_perr); end
         bus.awvalid = $urandom_range(0, 3) == 0;
         bus.awready = $urandom_range(0, 3) != 0;
         bus.awaddr  = ($urandom_range(0, 2) != 0) ? CON : {8'h00, 32'($urandom)};
         bus.awlen   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
         bus.wvalid  = $urandom_range(0, 2) == 0;
         bus.wready  = $urandom_range(0, 3) != 0;
         bus.wdata   = {$urandom, $urandom, $urandom, $urandom};
         bus.wstrb   = strbs[$urandom_range(0, 5)];
         bus.wlast   = $urandom_range(0, 3) != 0;
         char_ready  = $urandom_range(0, 2) == 0;
         @(negedge clk);
      end
      bus.awvalid = 0; bus.wvalid = 0; char_ready = 0;
   endtask

   task automatic test_wdog_pulse();
      do_reset(0);
      for (int i = 0; i < 3*WDOG; i++) begin
         retire = (i % 1000) == 999;
         @(negedge clk);
      end
      retire = 0;
      checks++; if (wdog_fail !== 1'b0) begin errors++; $display("FAIL wdog_pulse: got %b want 0", wdog_fail); end
      checks++; if (wdog_fail !== m_wdog) begin errors++; $display("FAIL wdog_pulse_model: got %b want %b", wdog_fail, m_wdog); end
   endtask

   task automatic test_wdog_fail();
      do_reset(0);
      repeat (WDOG - 1) @(negedge clk);
      checks++; if (wdog_fail !== 1'b0) begin errors++; $display("FAIL wdog_before_wrap: got %b want 0", wdog_fail); end
      @(negedge clk);
      checks++; if (wdog_fail !== 1'b1) begin errors++; $display("FAIL wdog_at_wrap: got %b want 1", wdog_fail); end
      checks++; if (wdog_fail !== m_wdog) begin errors++; $display("FAIL wdog_model: got %b want %b", wdog_fail, m_wdog); end
      retire = 1;
      repeat (10) @(negedge clk);
      checks++; if (wdog_fail !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b want 1", wdog_fail); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_same_cycle();
      test_filtered();
      test_fifo_full();
      test_proto();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_wdog_pulse();
      test_wdog_fail();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
